// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared types for the sequential matrix-multiply controller: FSM state encoding
// and helpers for the flat row-major packed matrix port format.
package matmul_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a loop counter spanning 0..dim-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_mac_unit.sv
// Combinational multiply-accumulate step: acc_out = (clear ? 0 : acc_in) + a*b.
// MATMUL_SAT_EN selects unsigned saturation; otherwise the sum wraps modulo 2^bitlength.
module mac_unit #(
  parameter int bitlength = 8
) (
  input  logic [bitlength-1:0] a,
  input  logic [bitlength-1:0] b,
  input  logic [bitlength-1:0] acc_in,
  input  logic                 clear,
  output logic [bitlength-1:0] acc_out
);

  logic [bitlength-1:0]   base;
  logic [2*bitlength-1:0] prod;

  always_comb begin
    base = clear ? '0 : acc_in;
    prod = a * b;
  end

`ifdef MATMUL_SAT_EN
  logic [2*bitlength:0] sum;

  // A clamped base equals the maximum, so any further add re-clamps: stays saturated.
  always_comb begin
    sum = {1'b0, prod} + {{(bitlength+1){1'b0}}, base};
    if (sum > {{(bitlength+1){1'b0}}, {bitlength{1'b1}}}) begin
      acc_out = '1;
    end else begin
      acc_out = sum[bitlength-1:0];
    end
  end
`else
  always_comb begin
    acc_out = base + prod[bitlength-1:0];
  end
`endif

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequential C = A x B controller: latches A/B on start, walks the i/j/k loop nest
// with one shared MAC per cycle, and presents C under a valid/ready handshake.
module matmul_seq_ctrl
  import matmul_seq_ctrl_pkg::*;
#(
  parameter int bitlength = 8,
  parameter int M1_D1     = 3,
  parameter int M1_D2     = 4,
  parameter int M2_D2     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 start_ready,
  input  logic [M1_D1*M1_D2*bitlength-1:0]     AI,
  input  logic [M1_D2*M2_D2*bitlength-1:0]     BI,
  output logic                                 busy,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [M1_D1*M2_D2*bitlength-1:0]     CO
);

  localparam int unsigned IW = idx_width(M1_D1);
  localparam int unsigned KW = idx_width(M1_D2);
  localparam int unsigned JW = idx_width(M2_D2);

  localparam logic [IW-1:0] I_LAST = IW'(M1_D1 - 1);
  localparam logic [KW-1:0] K_LAST = KW'(M1_D2 - 1);
  localparam logic [JW-1:0] J_LAST = JW'(M2_D2 - 1);

  state_t state, state_nx;

  logic [bitlength-1:0] a_r [M1_D1][M1_D2];
  logic [bitlength-1:0] b_r [M1_D2][M2_D2];
  logic [bitlength-1:0] c_r [M1_D1][M2_D2];

  // Loop counters are zero-based here; i=j=k=1 of the loop nest maps to 0.
  logic [IW-1:0]        i;
  logic [KW-1:0]        k;
  logic [JW-1:0]        j;
  logic [bitlength-1:0] acc;
  logic [bitlength-1:0] mac_out;
  logic                 i_last, j_last, k_last;

  always_comb begin
    i_last = (i == I_LAST);
    j_last = (j == J_LAST);
    k_last = (k == K_LAST);
  end

  mac_unit #(
    .bitlength(bitlength)
  ) u_mac (
    .a      (a_r[i][k]),
    .b      (b_r[k][j]),
    .acc_in (acc),
    .clear  (k == '0),
    .acc_out(mac_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      acc   <= '0;
      for (int unsigned r = 0; r < M1_D1; r++)
        for (int unsigned c = 0; c < M1_D2; c++)
          a_r[r][c] <= '0;
      for (int unsigned r = 0; r < M1_D2; r++)
        for (int unsigned c = 0; c < M2_D2; c++)
          b_r[r][c] <= '0;
      for (int unsigned r = 0; r < M1_D1; r++)
        for (int unsigned c = 0; c < M2_D2; c++)
          c_r[r][c] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int unsigned r = 0; r < M1_D1; r++)
              for (int unsigned c = 0; c < M1_D2; c++)
                a_r[r][c] <= AI[(r*M1_D2+c)*bitlength +: bitlength];
            for (int unsigned r = 0; r < M1_D2; r++)
              for (int unsigned c = 0; c < M2_D2; c++)
                b_r[r][c] <= BI[(r*M2_D2+c)*bitlength +: bitlength];
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        ST_RUN: begin
          acc <= mac_out;
          if (k_last) begin
            c_r[i][j] <= mac_out;
            k         <= '0;
            if (j_last) begin
              j <= '0;
              i <= i_last ? '0 : i + IW'(1);
            end else begin
              j <= j + JW'(1);
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (i_last && j_last && k_last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    CO = '0;
    for (int unsigned r = 0; r < M1_D1; r++)
      for (int unsigned c = 0; c < M2_D2; c++)
        CO[(r*M2_D2+c)*bitlength +: bitlength] = c_r[r][c];
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: latency, results, DONE hold, mid-run reset,
// and operand isolation after start. Honours MATMUL_SAT_EN for expected values.
module tb_matmul_seq_ctrl;

  localparam int BL = 8;
  localparam int D1 = 3;
  localparam int D2 = 4;
  localparam int D3 = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 out_ready = 1'b0;
  logic [D1*D2*BL-1:0]  AI = '0;
  logic [D2*D3*BL-1:0]  BI = '0;
  logic                 start_ready, busy, out_valid;
  logic [D1*D3*BL-1:0]  CO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matmul_seq_ctrl #(
    .bitlength(BL),
    .M1_D1    (D1),
    .M1_D2    (D2),
    .M2_D2    (D3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_ready(start_ready),
    .AI         (AI),
    .BI         (BI),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .CO         (CO)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product over the flat row-major operand format.
  function automatic logic [D1*D3*BL-1:0] ref_mul(input logic [D1*D2*BL-1:0] a,
                                                  input logic [D2*D3*BL-1:0] b);
    logic [D1*D3*BL-1:0] res;
    int unsigned acc, p;
    res = '0;
    for (int r = 0; r < D1; r++)
      for (int c = 0; c < D3; c++) begin
        acc = 0;
        for (int x = 0; x < D2; x++) begin
          p = a[(r*D2+x)*BL +: BL] * b[(x*D3+c)*BL +: BL];
`ifdef MATMUL_SAT_EN
          acc = (acc + p > 255) ? 255 : acc + p;
`else
          acc = (acc + p) & 32'hFF;
`endif
        end
        res[(r*D3+c)*BL +: BL] = acc[BL-1:0];
      end
    return res;
  endfunction

  // Accept start, then count edges until out_valid; optionally scramble inputs meanwhile.
  task automatic run_op(input bit scramble, output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      if (scramble) begin
        AI    = {$urandom, $urandom, $urandom};
        BI    = {$urandom, $urandom};
        start = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic release_done(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 64'(start_ready), 64'd1);
    check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  logic [D1*D2*BL-1:0] a2;
  logic [D2*D3*BL-1:0] b2;
  logic [D1*D3*BL-1:0] held, exp6;
  int cyc;

  initial begin
    for (int r = 0; r < D1; r++)
      for (int c = 0; c < D2; c++)
        a2[(r*D2+c)*BL +: BL] = 8'(r*D2 + c + 1);
    b2 = 64'h0100_0000_0000_0001;

    repeat (2) @(posedge clk); #1;
    check("rst_ready", 64'(start_ready), 64'd1);
    check("rst_busy",  64'(busy),        64'd0);
    check("rst_valid", 64'(out_valid),   64'd0);
    check("rst_co",    64'(CO),          64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All ones times all twos
    AI = {12{8'd1}};
    BI = {8{8'd2}};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t1_busy",  64'(busy),        64'd1);
    check("t1_ready", 64'(start_ready), 64'd0);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t1_latency", 64'(cyc - 1), 64'd24);
    check("t1_co", 64'(CO), 64'h0808_0808_0808);
    release_done("t1");

    // Column selection
    AI = a2;
    BI = b2;
    run_op(1'b0, cyc);
    check("t2_latency", 64'(cyc), 64'd24);
    check("t2_co", 64'(CO), 64'h0C09_0805_0401);
    release_done("t2");

    // Overflow: wrap or saturate
    AI = '1;
    BI = '1;
    run_op(1'b0, cyc);
`ifdef MATMUL_SAT_EN
    check("t3_co", 64'(CO), 64'hFFFF_FFFF_FFFF);
`else
    check("t3_co", 64'(CO), 64'h0404_0404_0404);
`endif

    // Hold in DONE with start toggling
    held = CO;
    for (int n = 0; n < 10; n++) begin
      start = ~start;
      AI = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      check("t4_valid", 64'(out_valid),   64'd1);
      check("t4_ready", 64'(start_ready), 64'd0);
      check("t4_co",    64'(CO),          64'(held));
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
    check("t4_idle_ready", 64'(start_ready), 64'd1);
    check("t4_no_queue",   64'(busy),        64'd0);
    @(posedge clk); #1;
    check("t4_still_idle", 64'(busy), 64'd0);

    // Reset in the middle of RUN
    AI = a2;
    BI = {8{8'd3}};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("t5_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_ready", 64'(start_ready), 64'd1);
    check("t5_busy",  64'(busy),        64'd0);
    check("t5_valid", 64'(out_valid),   64'd0);
    check("t5_co",    64'(CO),          64'd0);
    AI = a2;
    BI = b2;
    run_op(1'b0, cyc);
    check("t5_latency", 64'(cyc), 64'd24);
    check("t5_co_after", 64'(CO), 64'h0C09_0805_0401);
    release_done("t5");

    // Operands scrambled after the accepted start
    AI = {32'h1F3A_C207, 32'h9B44_0E81, 32'h6D12_F0A5};
    BI = {32'h0A03_FF17, 32'h2C05_8E09};
    exp6 = ref_mul(AI, BI);
    run_op(1'b1, cyc);
    check("t6_latency", 64'(cyc), 64'd24);
    check("t6_co", 64'(CO), 64'(exp6));
    release_done("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequential controller that computes C = A x B with a single time-shared multiply-accumulate (MAC) datapath instead of the fully unrolled combinational multiplier array. Operands use the same packed 2-D port format (`PORT_2D`) as the combinational multiplier. The block latches both operands on a start handshake, walks the i/j/k loop nest one MAC per cycle, and presents the result matrix under a valid/ready output handshake. It is intended for RBM layers where the area of the unrolled multiplier is not affordable.

Parameters:
bitlength, 8, element width of A, B, C and the accumulator (unsigned)
M1_D1, 3, rows of A and C
M1_D2, 4, columns of A and rows of B (inner/reduction dimension)
M2_D2, 2, columns of B and C

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  request a new multiply; accepted only when start_ready=1
start_ready  output  1  high only in IDLE
AI  input  `PORT_2D(M1_D1,M1_D2,bitlength)`  matrix A, sampled on the accepted start
BI  input  `PORT_2D(M1_D2,M2_D2,bitlength)`  matrix B, sampled on the accepted start
busy  output  1  high in RUN
out_valid  output  1  high in DONE; result available on CO
out_ready  input  1  consumer accepts the result
CO  output  `PORT_2D(M1_D1,M2_D2,bitlength)`  registered result matrix

Behaviour:
- Reset, decided: one clock; reset is synchronous and active-low (clk, rst_n). When rst_n=0 at a rising edge: state=IDLE; start_ready=1; busy=0; out_valid=0; CO, the operand registers, i/j/k counters and the accumulator are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches AI/BI into internal registers, sets i=j=k=1, and moves to RUN. AI/BI are don't-care after that edge.
- RUN: each edge performs one MAC: acc_next = (k==1 ? 0 : acc) + A[i][k]*B[k][j]. The sum is truncated to bitlength (modulo 2^bitlength), which matches the combinational multiplier. When k==M1_D2, acc_next is written to C[i][j], k resets to 1, j increments; when j wraps, i increments. Otherwise k increments.
- Final MAC (i=M1_D1, j=M2_D2, k=M1_D2): write C, then go to DONE.
- Latency: N = M1_D1*M2_D2*M1_D2 MAC cycles. If start is accepted at edge t0, out_valid is high after edge t0+N (default N=24).
- CO elements update in place during RUN. CO is only meaningful while out_valid=1. CO holds its value in IDLE until the next run overwrites it.
- DONE: out_valid=1 and CO is stable. out_ready=1 at an edge moves the FSM to IDLE. With out_ready=0 the FSM holds indefinitely.
- start while in RUN or DONE is ignored and not queued, including start and out_ready both high in DONE; start must be re-presented in IDLE.
- Reset in the middle of RUN or DONE aborts the operation, with no partial result flagged.
- Dimensions of 1 are legal; with M1_D2=1 every MAC writes C directly.

Optional Feature:
Macro MATMUL_SAT_EN.
- Defined: the accumulator uses unsigned saturation. Any product or sum exceeding 2^bitlength-1 clamps to 2^bitlength-1, and the value stays clamped for the rest of that element.
- Undefined: modulo-2^bitlength wrap, bit-exact with the combinational multiplier.

Decomposition:
- config.v (shared include): `PORT_2D`, `DEFINE_PACK_VAR`, `UNPACK_2D_ARRAY` / `PACK_2D_ARRAY` for operand and result packing, plus the FSM state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) as shared defines.
- One sub-module: mac_unit (bitlength, combinational). Inputs a, b, acc_in, clear; output acc_out. It contains the MATMUL_SAT_EN wrap/saturate logic so it can be tested standalone.

Test Plan:
- All A=1, all B=2; pulse start; out_ready=1 → out_valid rises exactly 24 cycles after the start edge, every C=8, FSM back in IDLE on the next edge.
- A rows {1,2,3,4},{5,6,7,8},{9,10,11,12}; B[1][1]=1, B[4][2]=1, rest 0 → C={1,4},{5,8},{9,12}.
- All A=B=255 → macro undefined: every C=4 (260100 mod 256). MATMUL_SAT_EN defined: every C=255.
- Hold out_ready=0 for 10 cycles in DONE while toggling start → out_valid and CO stay stable, start_ready=0; a later out_ready=1 returns the FSM to IDLE.
- Assert rst_n=0 at RUN cycle 10 → next cycle all outputs 0 and state IDLE. A fresh start with the test-2 operands then yields the correct result.
- Change AI/BI randomly every cycle after the accepted start → result equals the product of the operand values present on the start edge.
